// File: rtl/regfile_2r1w_pkg.sv
// Shared widths and types for the 32x32 two-read/one-write register file.
package regfile_2r1w_pkg;

  localparam int unsigned REG_COUNT  = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

  localparam reg_addr_t ZERO_REG = 5'd0;

endpackage

// File: rtl/regfile_2r1w_decoder.sv
// Enable-gated 5-to-32 one-hot decoder producing per-register write strobes.
module decoder1to32
  import regfile_2r1w_pkg::*;
(
  input  logic                 i_enable,
  input  reg_addr_t            i_addr,
  output logic [REG_COUNT-1:0] o_onehot_c
);

  always_comb begin
    o_onehot_c = '0;
    if (i_enable) begin
      o_onehot_c[i_addr] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_2r1w_mux.sv
// 32:1 selector of 32-bit words, used once per read port.
module mux32to1by32
  import regfile_2r1w_pkg::*;
(
  input  reg_data_t [REG_COUNT-1:0] i_data,
  input  reg_addr_t                 i_sel,
  output reg_data_t                 o_data_c
);

  assign o_data_c = i_data[i_sel];

endmodule

// File: rtl/regfile_2r1w.sv
// 32-entry x 32-bit register file: two combinational read ports, one synchronous
// write port, register 0 hardwired to zero, optional write-to-read forwarding.
module regfile_2r1w
  import regfile_2r1w_pkg::*;
#(
  parameter bit BYPASS = 1'b1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      reg_write,
  input  reg_addr_t write_addr,
  input  reg_data_t write_data,
  input  reg_addr_t read_addr1,
  input  reg_addr_t read_addr2,
  output reg_data_t read_data1,
  output reg_data_t read_data2
);

  logic [REG_COUNT-1:0]      w_dec;
  logic [REG_COUNT-1:0]      w_we;
  reg_data_t                 r_regs [1:REG_COUNT-1];
  reg_data_t [REG_COUNT-1:0] w_rd_vec;
  reg_data_t                 w_mux1;
  reg_data_t                 w_mux2;
  logic                      w_wr_live;
  logic                      w_fwd1;
  logic                      w_fwd2;

  decoder1to32 u_dec (
    .i_enable   (reg_write),
    .i_addr     (write_addr),
    .o_onehot_c (w_dec)
  );

  // Register 0 is never written, whatever the decoder says.
  assign w_we = {w_dec[REG_COUNT-1:1], 1'b0};

  for (genvar g = 1; g < REG_COUNT; g++) begin : g_store
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_regs[g] <= '0;
      end else if (w_we[g]) begin
        r_regs[g] <= write_data;
      end
    end
  end

  always_comb begin
    w_rd_vec    = '0;
    for (int unsigned i = 1; i < REG_COUNT; i++) begin
      w_rd_vec[i] = r_regs[i];
    end
  end

  mux32to1by32 u_mux1 (
    .i_data   (w_rd_vec),
    .i_sel    (read_addr1),
    .o_data_c (w_mux1)
  );

  mux32to1by32 u_mux2 (
    .i_data   (w_rd_vec),
    .i_sel    (read_addr2),
    .o_data_c (w_mux2)
  );

  // Forwarding is suppressed during reset so both ports read zero while it is held.
  assign w_wr_live = BYPASS && rst_n && reg_write && (write_addr != ZERO_REG);
  assign w_fwd1    = w_wr_live && (write_addr == read_addr1);
  assign w_fwd2    = w_wr_live && (write_addr == read_addr2);

  assign read_data1 = w_fwd1 ? write_data : w_mux1;
  assign read_data2 = w_fwd2 ? write_data : w_mux2;

endmodule
